// File: rtl/ccff_cfg_pkg.sv
// ============================================================================
// Module      : ccff_cfg_pkg
// Description : Shared types and constants for the configuration-chain loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ccff_state_t;

    localparam int c_def_word_w    = 32;
    localparam int c_clb_chain_len = 1024;
    localparam int c_io_chain_len  = 64;

endpackage : ccff_cfg_pkg

`default_nettype wire

// File: rtl/ccff_rb_deser.sv
// ============================================================================
// Module      : ccff_rb_deser
// Description : Collects chain-tail bits into words; flushes a left-aligned
//               partial word when the load completes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ccff_rb_deser #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              flush,
    input  logic              tail_bit,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] c_word_w = CW'(WORD_W);

    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic              w_emit;

    always_comb begin
        w_shift_next = {r_shift[WORD_W-2:0], tail_bit};
        w_cnt_next   = r_cnt + CW'(1);
        w_emit       = shift_en && ((w_cnt_next == c_word_w) || flush);
    end

    // clear has priority so an aborted load never produces another pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_emit) begin
                rb_data  <= w_shift_next << (c_word_w - w_cnt_next);
                rb_valid <= 1'b1;
                r_shift  <= '0;
                r_cnt    <= '0;
            end else if (shift_en) begin
                r_shift <= w_shift_next;
                r_cnt   <= w_cnt_next;
            end
        end
    end

endmodule : ccff_rb_deser

`default_nettype wire

// File: rtl/ccff_stream_loader.sv
// ============================================================================
// Module      : ccff_stream_loader
// Description : Serialises streamed configuration words MSB-first into a
//               tile configuration chain and captures the tail as readback.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ccff_stream_loader
    import ccff_cfg_pkg::*;
#(
    parameter int WORD_W    = c_def_word_w,
    parameter int CHAIN_LEN = c_clb_chain_len,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int BL_W  = $clog2(WORD_W + 1);
    localparam int SUM_W = CNT_W + BL_W;
    localparam logic [SUM_W-1:0] c_chain_len = SUM_W'(CHAIN_LEN);
    localparam logic [BL_W-1:0]  c_word_w    = BL_W'(WORD_W);

    ccff_state_t       r_state;
    ccff_state_t       w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [BL_W-1:0]   r_bits_left;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [SUM_W-1:0]  w_cnt_ext;
    logic [SUM_W-1:0]  w_held;
    logic              w_in_load;
    logic              w_shift_en;
    logic              w_last_bit;
    logic              w_accept;
    logic              w_clear;

    assign w_in_load  = (r_state == ST_LOAD);
    assign w_shift_en = w_in_load && (r_bits_left != '0);
    assign w_cnt_ext  = SUM_W'(r_bit_cnt);
    assign w_held     = w_cnt_ext + SUM_W'(r_bits_left);
    assign w_last_bit = ((w_cnt_ext + SUM_W'(1)) == c_chain_len);
    assign w_accept   = s_valid && s_ready;
    assign w_clear    = abort || (start && (r_state != ST_LOAD));

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) w_state_next = ST_LOAD;
                ST_LOAD:          if (w_shift_en && w_last_bit) w_state_next = ST_DONE;
                default:          w_state_next = ST_IDLE;
            endcase
        end
    end

    // a word may land while the last bit of the previous one shifts out
    always_comb begin
        ccff_clk_en = w_shift_en;
        s_ready     = w_in_load
                      && ((r_bits_left == '0) || ((r_bits_left == BL_W'(1)) && w_shift_en))
                      && (w_held < c_chain_len);
        busy        = w_in_load;
        done        = (r_state == ST_DONE);
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_shift     <= '0;
            r_bits_left <= '0;
            r_bit_cnt   <= '0;
        end else if (w_clear) begin
            r_bits_left <= '0;
            r_bit_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_shift     <= s_data;
                r_bits_left <= c_word_w;
            end else if (w_shift_en) begin
                r_shift     <= r_shift << 1;
                r_bits_left <= r_bits_left - BL_W'(1);
            end
            if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign ccff_head = r_shift[WORD_W-1];

    ccff_rb_deser #(
        .WORD_W (WORD_W)
    ) u_rb_deser (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .clear    (w_clear),
        .shift_en (w_shift_en),
        .flush    (w_last_bit && !abort),
        .tail_bit (ccff_tail),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

endmodule : ccff_stream_loader

`default_nettype wire

// File: tb/tb_ccff_stream_loader.sv
// ============================================================================
// Module      : tb_ccff_stream_loader
// Description : Directed bench driving a 20-bit chain model with 8-bit words.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ccff_stream_loader;

    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_clk_en;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              done;

    logic [CHAIN_LEN-1:0] chain;
    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   en_cnt   = 0;
    int                   gap_cnt  = 0;
    bit                   seen_en  = 1'b0;
    logic [WORD_W-1:0]    rb_q[$];

    ccff_stream_loader #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .prog_clk    (clk),
        .prog_rst_n  (rst_n),
        .start       (start),
        .abort       (abort),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .ccff_head   (ccff_head),
        .ccff_tail   (ccff_tail),
        .ccff_clk_en (ccff_clk_en),
        .rb_data     (rb_data),
        .rb_valid    (rb_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // chain model clocked by the gated programming clock
    always @(posedge clk) begin
        if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(negedge clk) begin
        if (ccff_clk_en) begin
            en_cnt++;
            seen_en = 1'b1;
        end else if (busy && seen_en) begin
            gap_cnt++;
        end
        if (rb_valid) rb_q.push_back(rb_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] rb_at(input int idx);
        if (idx < rb_q.size()) return rb_q[idx];
        return 'x;
    endfunction

    task automatic clear_mon();
        en_cnt  = 0;
        gap_cnt = 0;
        seen_en = 1'b0;
        rb_q.delete();
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        #1;
        while (!s_ready) begin
            @(negedge clk); #1;
            n++;
            if (n > 200) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        bit ok;
        s_data  = w;
        s_valid = 1'b1;
        wait_ready(ok);
        if (!ok) check("ready_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        #1;
        while (!done && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!done) check(tag, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_en(input int target);
        int n = 0;
        #1;
        while (en_cnt < target && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (en_cnt < target) check("en_timeout", 32'(en_cnt), 32'(target));
    endtask

    task automatic full_load(input int gap, input bit start_in_gap);
        bit ok;
        chain = 20'hABCDE;
        clear_mon();
        pulse_start();
        send_word(8'hA5);
        if (gap > 0) begin
            wait_ready(ok);
            if (!ok) check("gap_ready_timeout", 32'(ok), 32'd1);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                start = start_in_gap && (i == 0);
            end
            start = 1'b0;
        end
        send_word(8'h3C);
        send_word(8'hF0);
        wait_done("done_timeout");
    endtask

    initial begin
        #2;
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_ready",  32'(s_ready),     32'd0);
        check("rst_clk_en", 32'(ccff_clk_en), 32'd0);
        check("rst_head",   32'(ccff_head),   32'd0);
        check("rst_rb",     {23'd0, rb_valid, rb_data}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        full_load(0, 1'b0);
        check("full_en_cnt", 32'(en_cnt),  32'd20);
        check("full_gaps",   32'(gap_cnt), 32'd0);
        check("full_chain",  32'(chain),   32'hA53CF);
        check("full_done",   32'(done),    32'd1);
        check("full_busy",   32'(busy),    32'd0);
        check("full_rb_num", 32'(rb_q.size()), 32'd3);
        check("full_rb0",    32'(rb_at(0)), 32'hAB);
        check("full_rb1",    32'(rb_at(1)), 32'hCD);
        check("full_rb2",    32'(rb_at(2)), 32'hE0);

        full_load(2, 1'b1);
        check("starve_en_cnt", 32'(en_cnt),  32'd20);
        check("starve_gaps",   32'(gap_cnt), 32'd2);
        check("starve_chain",  32'(chain),   32'hA53CF);
        check("starve_done",   32'(done),    32'd1);
        check("starve_rb_num", 32'(rb_q.size()), 32'd3);
        check("starve_rb2",    32'(rb_at(2)), 32'hE0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("sa_done", 32'(done), 32'd0);
        check("sa_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        check("sa_idle_clk_en", 32'(ccff_clk_en), 32'd0);

        chain = 20'hABCDE;
        clear_mon();
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        wait_en(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("abort_en_cnt", 32'(en_cnt), 32'd10);
        check("abort_chain",  32'(chain),  32'h37A94);
        check("abort_rb_num", 32'(rb_q.size()), 32'd1);
        check("abort_rb0",    32'(rb_at(0)), 32'hAB);

        chain = 20'hABCDE;
        clear_mon();
        pulse_start();
        send_word(8'hA5);
        wait_en(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk_en", 32'(ccff_clk_en), 32'd0);
        check("arst_ready",  32'(s_ready),     32'd0);
        check("arst_busy",   32'(busy),        32'd0);
        check("arst_rb_vld", 32'(rb_valid),    32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        full_load(0, 1'b0);
        check("post_rst_en_cnt", 32'(en_cnt), 32'd20);
        check("post_rst_chain",  32'(chain),  32'hA53CF);
        check("post_rst_rb_num", 32'(rb_q.size()), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ccff_stream_loader

`default_nettype wire

// File: doc/ccff_stream_loader.md
Name: ccff_stream_loader

Overview:
- Upstream configuration-chain driver for the logical tiles.
- Accepts configuration words over a valid/ready stream and serialises them MSB-first onto the tile's `ccff_head`.
- Produces the clock-enable that gates `prog_clk` into the fabric, so the chain advances only when a valid bit is presented.
- Captures the bits falling out of `ccff_tail` as readback words, giving a read-while-write of the previous configuration.

Parameters:
- `WORD_W`, 32, width of one configuration/readback word.
- `CHAIN_LEN`, 1024, total configuration bits in the driven chain (≥1).
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, width of the bit counter; derived, not overridden.

Ports:
- `prog_clk`  in  1  programming clock; all state on the rising edge.
- `prog_rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `abort`  in  1  returns the block to IDLE from any state.
- `s_data`  in  `WORD_W`  configuration word; bit `[WORD_W-1]` is shifted first.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  word accepted when `s_valid && s_ready`.
- `ccff_head`  out  1  serial bit into the chain head.
- `ccff_tail`  in  1  serial bit from the chain tail.
- `ccff_clk_en`  out  1  enable for the external `prog_clk` gate; one chain shift per high cycle.
- `rb_data`  out  `WORD_W`  readback word; first-out tail bit sits at the MSB.
- `rb_valid`  out  1  one-cycle strobe qualifying `rb_data`; no backpressure.
- `busy`  out  1  high in LOAD.
- `done`  out  1  high in DONE; held until `start` or `abort`.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Shift register, `bits_left`, `bit_cnt` and readback registers all 0.
- States:
  - IDLE: `start` → LOAD, clear `bit_cnt`.
  - LOAD: → DONE in the cycle where `bit_cnt` reaches `CHAIN_LEN`; `abort` → IDLE.
  - DONE: `start` → LOAD; `abort` → IDLE.
- `s_ready` = (state==LOAD) && (`bits_left`==0 || (`bits_left`==1 && `ccff_clk_en`)) && (`bit_cnt` + `bits_left` < `CHAIN_LEN`).
  - Back-to-back words stream with zero bubble.
  - No word is accepted once enough bits are held to finish the chain.
- On accept: the shift register loads `s_data` and `bits_left` = `WORD_W`. The first bit of that word appears on `ccff_head` in the next cycle.
- `ccff_head` = shift register MSB. It is driven from registers only, never combinationally from `s_data`.
- `ccff_clk_en` = (state==LOAD) && (`bits_left` != 0). On each such cycle:
  - the shift register shifts left;
  - `bits_left` decrements;
  - `bit_cnt` increments.
- Starvation (`bits_left`==0, `s_valid` low): `ccff_clk_en` drops and the chain holds. No bit is lost or duplicated.
- Last word when `CHAIN_LEN` mod `WORD_W` ≠ 0: only its top (`CHAIN_LEN` mod `WORD_W`) bits are shifted; its low bits are discarded.
- Entering DONE: `ccff_clk_en` deasserts in the same cycle `bit_cnt` == `CHAIN_LEN` is registered. Exactly `CHAIN_LEN` enabled cycles occur per load.
- Readback:
  - On every `ccff_clk_en` cycle, `ccff_tail` is shifted into the readback register LSB.
  - After each `WORD_W` collected bits, `rb_data` is updated and `rb_valid` pulses the following cycle.
  - A final partial word is flushed on DONE entry, left-aligned and zero-padded, with one `rb_valid` pulse.
  - Total `rb_valid` pulses per load = ceil(`CHAIN_LEN`/`WORD_W`).
- `start` in LOAD is ignored.
- `abort` in the same cycle as `start` → `abort` wins.
- `abort` mid-load: the chain is left partially shifted, `done`=0, the partial readback is discarded, and no further `rb_valid` pulse is produced.
- Asynchronous reset mid-load: `ccff_clk_en` falls immediately (no further shift edges); the contents of the partially shifted chain are undefined and must be reloaded.

Decomposition:
- Shared package `ccff_cfg_pkg` holds:
  - the state enum (IDLE, LOAD, DONE);
  - default `WORD_W`;
  - the per-tile chain-length constants (the CLB-tile value, IO-tile value).
- One sub-module, `ccff_rb_deser`: the readback deserialiser (shift-in, count to `WORD_W`, flush-on-done, `rb_valid` pulse).
- The loader FSM, serialiser and counters stay in the top module.

Test Plan (`WORD_W`=8, `CHAIN_LEN`=20, chain model = 20-bit shift register on gated `prog_clk`, preloaded 0xABCDE):
- Full load: `start`, words 0xA5, 0x3C, 0xF0 streamed with `s_valid` held high → exactly 20 `ccff_clk_en` cycles, no gaps between words, model holds 0xA53CF, `done`=1, and the low nibble of 0xF0 is never shifted.
- Readback: same run → `rb_valid` pulses with 0xAB, 0xCD, then the flushed partial 0xE0; three pulses total.
- Starvation: 2-cycle `s_valid` gap after the first word → `ccff_clk_en` low for those cycles, final chain content still 0xA53CF, total enabled cycles 20.
- Abort: `abort` after 10 enabled cycles → IDLE next cycle, `busy`=0, `done`=0, no further `ccff_clk_en`; one `rb_valid` (0xAB) seen only.
- Reset: `prog_rst_n` low mid-load, asynchronous to `prog_clk` → `ccff_clk_en`, `s_ready`, `busy` and `rb_valid` go to 0 immediately; after release a fresh `start` loads the chain correctly.
- Control corner cases:
  - `start` pulsed during LOAD → ignored, bit count unchanged.
  - `start` and `abort` together in DONE → IDLE.
